btn_debounce_multi: RTL and testbench
=====================================

// Module: btn_debounce_multi
// PURPOSE
//  N-channel push-button conditioner. Sits between the raw board buttons (bouncy_btns)
//  and main's control logic. Per channel: synchronise, debounce by stable-count,
//  publish a clean level plus one-cycle press/release strobes. Replaces ad-hoc
//  single-button debouncing with one parametrised block sized by channel count and time.
// PARAMETERS
//  N_BTN            5          number of button channels
//  CNT_W            20         debounce counter width; requires DEBOUNCE_CYC < 2**CNT_W
//  DEBOUNCE_CYC     1000000    consecutive stable cycles to accept a change (10 ms @ 100 MHz); >= 2
//  ACTIVE_HIGH      1          1: pressed = input high; 0: input inverted at synchroniser
//  REPEAT_DELAY_CYC 50000000   (DEBOUNCE_REPEAT_EN only) hold time before first repeat
//  REPEAT_RATE_CYC  10000000   (DEBOUNCE_REPEAT_EN only) period between repeat strobes
// PORTS
//  clk           in   1      system clock, all logic rising-edge
//  rst_n         in   1      asynchronous active-low reset
//  bouncy_btns   in   N_BTN  raw asynchronous button inputs
//  btn_level     out  N_BTN  debounced level, 1 = pressed
//  btn_press     out  N_BTN  1-cycle strobe on accepted press (and repeats, if enabled)
//  btn_release   out  N_BTN  1-cycle strobe on accepted release
//  btn_any       out  1      OR of btn_level, registered with it
// BEHAVIOUR
//  - Reset: all outputs 0; sync FFs 0 (released); all counters 0; FSMs -> IDLE. Async assert,
//    sync deassert. Reset mid-count discards the count; a button held through reset
//    release is reported as a fresh press after full latency.
//  - Sync: 2-FF synchroniser per channel (after ACTIVE_HIGH polarity fix); output s[i].
//  - Per-channel FSM: IDLE (level 0, s=0) -> PRESS_WAIT when s=1; PRESS_WAIT counts
//    each cycle s=1, returns to IDLE and clears count on any s=0;
//    at count==DEBOUNCE_CYC-1 with s=1 -> HELD: level<=1, btn_press<=1 for one cycle, cnt<=0.
//    HELD -> REL_WAIT when s=0; symmetric; on acceptance -> IDLE, level<=0, btn_release 1 cycle.
//  - Latency: raw edge to btn_level/strobe = DEBOUNCE_CYC+2 clk edges; strobe coincident
//    with first cycle of new level.
//  - Glitches shorter than DEBOUNCE_CYC sync'd cycles: no output change, counter restarts.
//  - Channels fully independent; simultaneous presses strobe in the same cycle.
//  - btn_press and btn_release never both 1 on a channel in the same cycle.
//  - Counter never wraps: cleared on acceptance or abort, max value DEBOUNCE_CYC-1.
// CONFIGURATION
//  DEBOUNCE_REPEAT_EN defined: in HELD, per-channel repeat counter runs from press
//    acceptance; extra btn_press strobe when it reaches REPEAT_DELAY_CYC, then every
//    REPEAT_RATE_CYC while held. Cleared on leaving HELD (including a REL_WAIT that aborts
//    back to HELD restarts nothing: counter keeps running only in HELD/REL_WAIT).
//  DEBOUNCE_REPEAT_EN undefined: exactly one btn_press per accepted press; repeat
//    parameters unused; no repeat counter logic synthesised.
// TESTING  (bench params: DEBOUNCE_CYC=4, CNT_W=4, REPEAT_DELAY_CYC=8, REPEAT_RATE_CYC=4)
//  1 bouncy_btns[0] 0->1 held 20 cycles -> btn_level[0]=1 and btn_press[0] 1-cycle pulse
//    exactly 6 edges after input change; btn_any=1; others stay 0.
//  2 bouncy_btns[0] high 3 cycles then low -> no level change, no strobes.
//  3 release after test 1, input 1->0 -> btn_level[0]=0, btn_release[0] pulse 6 edges later.
//  4 bouncy_btns=5'b11111 same cycle -> btn_press=5'b11111 in one cycle; btn_level=5'b11111.
//  5 rst_n low 1 cycle at count 2 mid-press -> outputs 0 at once; held button re-reported
//    6 edges after rst_n high.
//  6 DEBOUNCE_REPEAT_EN, hold 30 cycles -> btn_press pulses at accept, +8, +12, +16, ...;
//    none after release; undefined build -> single pulse only.

Source files
------------

// File: rtl/btn_debounce_multi_if.sv
// Button conditioner signal bundle: raw inputs from the board, clean levels and strobes back.
// The master side owns the raw buttons; the slave side is the debouncer.
interface btn_debounce_multi_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] bouncy_btns;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             btn_any;

  modport master (
    output bouncy_btns,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_any
  );

  modport slave (
    input  bouncy_btns,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_any
  );
endinterface

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: 2-FF sync, stable-count debounce, level + press/release strobes.
// Optional auto-repeat of btn_press while held is compiled in with `define DEBOUNCE_REPEAT_EN.
module btn_debounce_multi #(
  parameter int N_BTN            = 5,
  parameter int CNT_W            = 20,
  parameter int DEBOUNCE_CYC     = 1000000,
  parameter bit ACTIVE_HIGH      = 1'b1,
  parameter int REPEAT_DELAY_CYC = 50000000,
  parameter int REPEAT_RATE_CYC  = 10000000
) (
  input logic                 clk,
  input logic                 rst_n,
  btn_debounce_multi_if.slave btn_if
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  if (DEBOUNCE_CYC < 2 || DEBOUNCE_CYC >= 2**CNT_W ||
      REPEAT_RATE_CYC < 1 || REPEAT_RATE_CYC > REPEAT_DELAY_CYC) begin : g_bad_params
    $error("btn_debounce_multi: inconsistent debounce/repeat parameters");
  end

  logic [N_BTN-1:0] level_vec;
  logic [N_BTN-1:0] level_next_vec;
  logic [N_BTN-1:0] press_vec;
  logic [N_BTN-1:0] release_vec;
  logic             any_reg;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    logic             raw_fixed;
    logic             sync1_reg, s_reg;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg, press_reg, release_reg;
    logic             level_next, press_next, release_next;
    logic             rep_fire;

    assign raw_fixed = ACTIVE_HIGH ? btn_if.bouncy_btns[gi] : ~btn_if.bouncy_btns[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_reg <= 1'b0;
        s_reg     <= 1'b0;
      end else begin
        sync1_reg <= raw_fixed;
        s_reg     <= sync1_reg;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg   <= IDLE;
        cnt_reg     <= '0;
        level_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        state_reg   <= state_next;
        cnt_reg     <= cnt_next;
        level_reg   <= level_next;
        press_reg   <= press_next;
        release_reg <= release_next;
      end
    end

    // The cycle that leaves IDLE/HELD is already the first stable sample, hence cnt starts at 1.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
        IDLE: if (s_reg) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_W'(1);
        end
        PRESS_WAIT: if (!s_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + CNT_W'(1);
        end
        HELD: if (!s_reg) begin
          state_next = REL_WAIT;
          cnt_next   = CNT_W'(1);
        end
        REL_WAIT: if (s_reg) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + CNT_W'(1);
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    always_comb begin
      level_next   = (state_next == HELD) || (state_next == REL_WAIT);
      press_next   = ((state_reg == PRESS_WAIT) && s_reg && (cnt_reg == CNT_LAST)) || rep_fire;
      release_next = (state_reg == REL_WAIT) && !s_reg && (cnt_reg == CNT_LAST);
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int             REP_W      = $clog2(REPEAT_DELAY_CYC + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY_CYC - REPEAT_RATE_CYC);
    logic [REP_W-1:0] rep_reg;

    // Fires only while truly held, so a repeat can never collide with a release strobe.
    assign rep_fire = (state_reg == HELD) && s_reg && (rep_reg == REP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_reg <= '0;
      end else if (state_next == IDLE || state_next == PRESS_WAIT || state_reg == PRESS_WAIT) begin
        rep_reg <= '0;
      end else if (rep_fire) begin
        rep_reg <= REP_RELOAD;
      end else if (rep_reg != REP_LAST) begin
        rep_reg <= rep_reg + REP_W'(1);
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign level_vec[gi]      = level_reg;
    assign level_next_vec[gi] = level_next;
    assign press_vec[gi]      = press_reg;
    assign release_vec[gi]    = release_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_reg <= 1'b0;
    end else begin
      any_reg <= |level_next_vec;
    end
  end

  assign btn_if.btn_level   = level_vec;
  assign btn_if.btn_press   = press_vec;
  assign btn_if.btn_release = release_vec;
  assign btn_if.btn_any     = any_reg;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi with a short debounce window (4 cycles, repeat 8/4).
// Expected values are hand-derived: accepted changes appear 6 edges after the raw input edge.
module tb_btn_debounce_multi;

  localparam int N = 5;
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  btn_debounce_multi_if #(.N_BTN(N)) bif ();

  btn_debounce_multi #(
    .N_BTN(N), .CNT_W(4), .DEBOUNCE_CYC(4), .ACTIVE_HIGH(1'b1),
    .REPEAT_DELAY_CYC(8), .REPEAT_RATE_CYC(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_if(bif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // j = cycles since press acceptance; a press strobe is due at j=0 and, with repeat, at 8, 12, 16...
  function automatic bit exp_rep(input int j);
    if (j == 0) return 1'b1;
    if (REP_EN && j >= 8 && ((j - 8) % 4) == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] any_vec();
    return {{(N-1){1'b0}}, bif.btn_any};
  endfunction

  initial begin
    rst_n = 1'b0;
    bif.bouncy_btns = '0;
    repeat (3) tick();
    check("rst_level", bif.btn_level, '0);
    check("rst_press", bif.btn_press, '0);
    check("rst_release", bif.btn_release, '0);
    check("rst_any", any_vec(), '0);
    rst_n = 1'b1;
    tick();
    $display("reset released");

    // Press channel 0 and hold 20 cycles
    bif.bouncy_btns = 5'b00001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("t1_level_k%0d", k), bif.btn_level, (k >= 6) ? 5'b00001 : 5'b00000);
      check($sformatf("t1_press_k%0d", k), bif.btn_press,
            (k >= 6 && exp_rep(k - 6)) ? 5'b00001 : 5'b00000);
      check($sformatf("t1_release_k%0d", k), bif.btn_release, '0);
      check($sformatf("t1_any_k%0d", k), any_vec(), (k >= 6) ? 5'b00001 : 5'b00000);
    end
    $display("press ch0 held 20 cycles");

    // Release channel 0
    bif.bouncy_btns = 5'b00000;
    for (int r = 1; r <= 8; r++) begin
      tick();
      check($sformatf("t3_level_r%0d", r), bif.btn_level, (r < 6) ? 5'b00001 : 5'b00000);
      check($sformatf("t3_press_r%0d", r), bif.btn_press,
            (r <= 2 && exp_rep(14 + r)) ? 5'b00001 : 5'b00000);
      check($sformatf("t3_release_r%0d", r), bif.btn_release, (r == 6) ? 5'b00001 : 5'b00000);
      check($sformatf("t3_any_r%0d", r), any_vec(), (r < 6) ? 5'b00001 : 5'b00000);
    end
    $display("release ch0");

    // Glitch: 3 cycles high is shorter than the debounce window
    bif.bouncy_btns = 5'b00001;
    repeat (3) tick();
    bif.bouncy_btns = 5'b00000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("t2_level_k%0d", k), bif.btn_level, '0);
      check($sformatf("t2_press_k%0d", k), bif.btn_press, '0);
      check($sformatf("t2_release_k%0d", k), bif.btn_release, '0);
    end
    $display("glitch ch0 3 cycles");

    // All channels pressed in the same cycle, then released together
    bif.bouncy_btns = 5'b11111;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("t4_level_k%0d", k), bif.btn_level, (k >= 6) ? 5'b11111 : 5'b00000);
      check($sformatf("t4_press_k%0d", k), bif.btn_press, (k == 6) ? 5'b11111 : 5'b00000);
    end
    bif.bouncy_btns = 5'b00000;
    for (int r = 1; r <= 8; r++) begin
      tick();
      check($sformatf("t4_rlevel_r%0d", r), bif.btn_level, (r < 6) ? 5'b11111 : 5'b00000);
      check($sformatf("t4_release_r%0d", r), bif.btn_release, (r == 6) ? 5'b11111 : 5'b00000);
      check($sformatf("t4_rpress_r%0d", r), bif.btn_press, '0);
    end
    $display("press/release all channels");

    // Reset in the middle of a ch2 press while ch0 is already held
    bif.bouncy_btns = 5'b00001;
    repeat (6) tick();
    check("t5_pre_level", bif.btn_level, 5'b00001);
    bif.bouncy_btns = 5'b00101;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_level", bif.btn_level, '0);
    check("t5_rst_press", bif.btn_press, '0);
    check("t5_rst_any", any_vec(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("t5_level_k%0d", k), bif.btn_level, (k >= 6) ? 5'b00101 : 5'b00000);
      check($sformatf("t5_press_k%0d", k), bif.btn_press, (k == 6) ? 5'b00101 : 5'b00000);
    end
    bif.bouncy_btns = 5'b00000;
    repeat (10) tick();
    check("t5_end_level", bif.btn_level, '0);
    $display("reset mid-press");

    // Long hold on ch1: repeat strobes only when the repeat feature is built in
    bif.bouncy_btns = 5'b00010;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("t6_level_k%0d", k), bif.btn_level, (k >= 6) ? 5'b00010 : 5'b00000);
      check($sformatf("t6_press_k%0d", k), bif.btn_press,
            (k >= 6 && exp_rep(k - 6)) ? 5'b00010 : 5'b00000);
    end
    bif.bouncy_btns = 5'b00000;
    for (int r = 1; r <= 12; r++) begin
      tick();
      check($sformatf("t6_press_r%0d", r), bif.btn_press,
            (r <= 2 && exp_rep(24 + r)) ? 5'b00010 : 5'b00000);
      check($sformatf("t6_release_r%0d", r), bif.btn_release, (r == 6) ? 5'b00010 : 5'b00000);
    end
    $display("hold ch1 30 cycles, repeat_en=%0d", REP_EN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
